mux8_sched: RTL and testbench
=============================

# mux8_sched

Round-robin scheduler for the shared 8:1 data multiplexer. Up to eight requesters contend for the single mux output. The block selects one winner and drives the 3-bit mux select. It holds the grant until the owner drops its request or a burst limit expires, then rotates priority. It sits between the requester agents and the gate-level 8:1 mux datapath and owns that mux instance.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles one requester keeps the grant. Legal range 1..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- req  input  8  request bit per requester; level-sensitive.
- d  input  8  data bit per requester; mux data inputs.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  registered mux select; index of the current owner.
- valid  output  1  registered; high while any grant is active.
- y  output  1  mux output. Combinational: d[sel] gated by valid.

## Operation
- State machine has two states.
  - IDLE: no owner.
  - GRANT: one owner, index sel.
- Internal registers:
  - ptr[2:0]: priority pointer.
  - cnt: width clog2(MAX_HOLD), minimum 1 bit.
- Arbitration function: search req starting at index ptr and wrapping mod 8. The first set bit wins.
- IDLE behaviour:
  - If req is nonzero, arbitrate. The winner loads gnt (one-hot), sel and valid=1, with cnt=0 and ptr=(winner+1) mod 8. Go to GRANT.
  - If req is zero, stay in IDLE.
- GRANT behaviour: a release event occurs when req[sel]==0 or cnt==MAX_HOLD-1.
  - No release: cnt increments. gnt, sel and ptr hold.
  - Release with req nonzero: arbitrate from ptr and load the new winner in the same edge, with no dead cycle.
    - The current owner can win again only if no other request is pending. In that case cnt resets to 0.
    - ptr updates to winner+1.
  - Release with req zero: gnt=0 and valid=0. sel holds its last value. Go to IDLE.
- While in GRANT, changes to non-owner request bits never pre-empt the owner.
- With MAX_HOLD=1 the block re-arbitrates every cycle and gives pure round-robin.
- y: valid ? d[sel] : 0. There is no registering on the data path.

## Timing
- Reset values: gnt=8'h00, sel=3'd0, valid=0, y=0, ptr=0, cnt=0, state IDLE.
- rst_n low overrides all other inputs at the edge, including mid-grant. Outputs read reset values after that edge.
- Request to grant latency:
  - From IDLE, req sampled at edge k gives gnt visible after edge k.
  - Handover at release is likewise one edge.
- Maximum continuous ownership is MAX_HOLD cycles.
- Worst-case wait for a continuously asserted requester is 7*MAX_HOLD cycles.
- A requester that drops req sees gnt deassert after the next edge. Its grant covers exactly the cycles from assertion through the edge where req was seen low.
- cnt wraps only by reload to 0. It never exceeds MAX_HOLD-1.
- y follows d within the same cycle and follows sel/valid one edge after arbitration.

## Structure
- Shared package/header holds:
  - N_REQ=8 and SEL_W=3.
  - State encodings ST_IDLE=1'b0 and ST_GRANT=1'b1.
  - A function or macro for round-robin priority search.
- Sub-module mux8_gate: the gate-level 8:1 AND-OR mux.
  - Inputs: sel[2:0] and d[7:0]. Output: one bit.
  - Instantiated once. Its output is ANDed with valid to form y.
- The arbitration logic, state register, ptr and cnt live in the top module.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF and d=8'hFF for 3 cycles. Expect gnt=0, sel=0, valid=0 and y=0 throughout.
- Single requester, MAX_HOLD=4: assert req=8'h20 for 10 cycles with d[5] toggling. Expect:
  - gnt=8'h20 and sel=5 from the first edge, continuous with no gap.
  - y mirrors d[5].
  - Idle one edge after req drops.
- Full load, MAX_HOLD=4: req=8'hFF from reset. Expect grants in order 0,1,2,...,7,0, each lasting exactly 4 cycles, with one-hot gnt at all times.
- Early release: owner 3 drops req after 2 cycles while req[6] is pending. Expect gnt=8'h40 and sel=6 at the next edge.
- Pointer wrap: with ptr=3, assert req=8'h44. Expect grant to 6 first, then 2 after release.
- Reset mid-grant: assert rst_n=0 during owner 5's grant, then release reset with req=8'h81. Expect:
  - Outputs cleared at the reset edge.
  - First grant goes to 0 (gnt=8'h01), then to 7.

Source files
------------

// File: rtl/mux8_sched_pkg.sv
// Shared constants, state encoding and the round-robin search used by the
// mux8_sched scheduler.
package mux8_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // First set request at or after ptr, wrapping modulo N_REQ.
  function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                       input logic [SEL_W-1:0] ptr);
    rr_pick_t         r;
    logic [SEL_W-1:0] idx;
    r.found = 1'b0;
    r.idx   = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!r.found && req[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux8_sched_if.sv
// Requester-side bus of the shared 8:1 mux: requests and data in, grant,
// select, valid and muxed data out.
interface mux8_sched_if;
  import mux8_sched_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] d;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             y;

  modport master (output req, output d, input gnt, input sel, input valid, input y);
  modport slave  (input req, input d, output gnt, output sel, output valid, output y);
endinterface

// File: rtl/mux8_gate.sv
// Gate-level 8:1 AND-OR multiplexer: each data bit is ANDed with a full
// decode of sel and the products are ORed together.
module mux8_gate
  import mux8_sched_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic [N_REQ-1:0] d,
  output logic             y
);

  logic [N_REQ-1:0] term;

  for (genvar i = 0; i < N_REQ; i++) begin : g_term
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
    assign term[i] = d[i] & ~(|(sel ^ IDX));
  end

  assign y = |term;

endmodule

// File: rtl/mux8_sched.sv
// Round-robin scheduler owning the shared 8:1 mux: grants one requester at a
// time, holds for at most MAX_HOLD cycles, then rotates priority.
module mux8_sched
  import mux8_sched_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mux8_sched_if.slave  bus
);

  localparam int                CNT_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  rr_pick_t         pick;
  logic             rel;
  logic             mux_y;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pick    = rr_pick(bus.req, ptr_q);
    rel     = (state_q == ST_IDLE) || !bus.req[sel_q] || (cnt_q == CNT_MAX);

    // The owner sits last in the search order, so it only re-wins when nobody else waits.
    if (rel) begin
      if (pick.found) begin
        state_d = ST_GRANT;
        gnt_d   = N_REQ'(1) << pick.idx;
        sel_d   = pick.idx;
        valid_d = 1'b1;
        cnt_d   = '0;
        ptr_d   = pick.idx + SEL_W'(1);
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  mux8_gate u_mux (
    .sel (sel_q),
    .d   (bus.d),
    .y   (mux_y)
  );

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.y     = valid_q & mux_y;

endmodule

// File: tb/tb_mux8_sched.sv
// Randomized and directed bench for mux8_sched, compared cycle by cycle
// against an ownership-level reference model.
module tb_mux8_sched;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int   m_sel = 0;
  int   m_ptr = 0;
  int   m_held = 0;
  bit   m_valid = 1'b0;
  bit   m_known = 1'b0;

  mux8_sched_if bus ();

  mux8_sched #(.MAX_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  // Ownership view: who holds the mux, for how many cycles so far, who is next in line.
  task automatic model_step(input logic r_n, input logic [7:0] req_v);
    int w;
    if (!r_n) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_ptr   = 0;
      m_held  = 0;
      m_known = 1'b1;
    end else if (!m_valid || !req_v[m_sel] || m_held == HOLD) begin
      w = model_pick(req_v, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_sel   = w;
        m_ptr   = (w + 1) % 8;
        m_held  = 1;
      end else begin
        m_valid = 1'b0;
        m_held  = 0;
      end
    end else begin
      m_held++;
    end
  endtask

  task automatic check_model(input string phase);
    logic [7:0] exp_gnt;
    logic [7:0] dv;
    dv      = bus.d;
    exp_gnt = m_valid ? (8'h01 << m_sel) : 8'h00;
    checkOutput({phase, "_gnt"}, bus.gnt, exp_gnt);
    checkOutput({phase, "_sel"}, {5'd0, bus.sel}, 8'(m_sel));
    checkOutput({phase, "_valid"}, {7'd0, bus.valid}, {7'd0, m_valid});
    checkOutput({phase, "_y"}, {7'd0, bus.y}, {7'd0, m_valid & dv[m_sel]});
    checkOutput({phase, "_onehot0"}, {7'd0, $onehot0(bus.gnt)}, 8'h01);
  endtask

  task automatic applyStimulus(input logic r_n, input logic [7:0] req_v, input logic [7:0] d_v);
    @(negedge clk);
    rst_n   = r_n;
    bus.req = req_v;
    bus.d   = d_v;
    #1;
    if (m_known)
      checkOutput("y_comb", {7'd0, bus.y}, {7'd0, m_valid & d_v[m_sel]});
    @(posedge clk);
    model_step(r_n, req_v);
    #1;
    check_model("cyc");
  endtask

  initial begin
    logic [7:0] d_v;
    logic [7:0] req_v;
    bus.req = 8'h00;
    bus.d   = 8'h00;

    // Reset held with everything asserted
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'hFF, 8'hFF);
      checkOutput("rst_gnt", bus.gnt, 8'h00);
      checkOutput("rst_y", {7'd0, bus.y}, 8'h00);
    end

    // Single requester 5 with toggling data
    for (int i = 0; i < 10; i++) begin
      d_v    = 8'($urandom());
      d_v[5] = i[0];
      applyStimulus(1'b1, 8'h20, d_v);
      checkOutput("single_gnt", bus.gnt, 8'h20);
      checkOutput("single_y", {7'd0, bus.y}, {7'd0, i[0]});
    end
    applyStimulus(1'b1, 8'h00, 8'hFF);
    checkOutput("single_idle", {7'd0, bus.valid}, 8'h00);
    checkOutput("single_sel_hold", {5'd0, bus.sel}, 8'd5);

    // Full load from reset: 0..7,0 each for HOLD cycles
    applyStimulus(1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 36; k++) begin
      applyStimulus(1'b1, 8'hFF, 8'($urandom()));
      checkOutput("full_sel", {5'd0, bus.sel}, 8'(((k - 1) / HOLD) % 8));
    end

    // Early release of owner 3 with 6 pending
    applyStimulus(1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 8'h48, 8'h00);
    checkOutput("early_first", bus.gnt, 8'h08);
    applyStimulus(1'b1, 8'h48, 8'h00);
    applyStimulus(1'b1, 8'h40, 8'h40);
    checkOutput("early_gnt", bus.gnt, 8'h40);
    checkOutput("early_sel", {5'd0, bus.sel}, 8'd6);

    // Pointer wrap: leave ptr at 3, then req 2 and 6
    applyStimulus(1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 8'h04, 8'h00);
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b1, 8'h44, 8'h00);
    checkOutput("wrap_first", bus.gnt, 8'h40);
    applyStimulus(1'b1, 8'h04, 8'h00);
    checkOutput("wrap_second", bus.gnt, 8'h04);

    // Reset during owner 5's grant, then 0 before 7
    applyStimulus(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'h20, 8'hFF);
    applyStimulus(1'b0, 8'h20, 8'hFF);
    checkOutput("midrst_gnt", bus.gnt, 8'h00);
    checkOutput("midrst_sel", {5'd0, bus.sel}, 8'd0);
    checkOutput("midrst_valid", {7'd0, bus.valid}, 8'h00);
    applyStimulus(1'b1, 8'h81, 8'hFF);
    checkOutput("midrst_first", bus.gnt, 8'h01);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h81, 8'hFF);
    checkOutput("midrst_next", bus.gnt, 8'h80);

    // Random traffic with sticky requests and occasional reset
    req_v = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0)
        req_v = ($urandom_range(0, 1) == 0) ? 8'($urandom()) : 8'($urandom() & $urandom());
      applyStimulus(($urandom_range(0, 59) != 0), req_v, 8'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
